// File: rtl/axis_pipeline_pkg.sv
// Shared constants and helpers for the AXI4-Stream register pipeline.
// Optional tkeep support is enabled by defining AXIS_PIPELINE_KEEP_EN.
package axis_pipeline_pkg;

   localparam int REG_BYPASS = 0;
   localparam int REG_SIMPLE = 1;
   localparam int REG_SKID   = 2;

   // Number of tkeep bits for a given tdata width (one bit per byte lane).
   function automatic int keep_width(input int data_width);
      return (data_width + 7) / 8;
   endfunction

endpackage

// File: rtl/axis_register_stage.sv
// One AXI4-Stream register stage: forward-registered (REG_SIMPLE) or full
// skid buffer with registered ready (REG_SKID). The payload is opaque here.
module axis_register_stage
   import axis_pipeline_pkg::*;
#(
   parameter int PAYLOAD_W = 33,
   parameter int REG_TYPE  = REG_SKID
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [PAYLOAD_W-1:0] s_payload_i,
   input  logic                 s_valid_i,
   output logic                 s_ready_o,
   output logic [PAYLOAD_W-1:0] m_payload_o,
   output logic                 m_valid_o,
   input  logic                 m_ready_i
);

   generate
      if (REG_TYPE == REG_SKID) begin : g_skid
         logic [PAYLOAD_W-1:0] m_payload_q;
         logic [PAYLOAD_W-1:0] temp_payload_q;
         logic                 m_valid_q, m_valid_d;
         logic                 temp_valid_q, temp_valid_d;
         logic                 s_ready_q, s_ready_d;
         logic                 load_out_from_in, load_out_from_temp, load_temp;

         // Ready is computed one cycle early so it can be registered: stay open
         // if downstream drains, or if the skid slot is guaranteed to be free.
         always_comb begin
            m_valid_d          = m_valid_q;
            temp_valid_d       = temp_valid_q;
            load_out_from_in   = 1'b0;
            load_out_from_temp = 1'b0;
            load_temp          = 1'b0;
            s_ready_d          = m_ready_i || (!temp_valid_q && (!m_valid_q || !s_valid_i));

            if (s_ready_q) begin
               if (m_ready_i || !m_valid_q) begin
                  m_valid_d        = s_valid_i;
                  load_out_from_in = 1'b1;
               end else begin
                  temp_valid_d = s_valid_i;
                  load_temp    = 1'b1;
               end
            end else if (m_ready_i) begin
               // Skid contents always leave before any new beat is admitted.
               m_valid_d          = temp_valid_q;
               temp_valid_d       = 1'b0;
               load_out_from_temp = 1'b1;
            end
         end

         // NOTE: state uses non-blocking assignments so every flop samples the
         // pre-edge values; blocking here would create order-dependent races.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               m_valid_q    <= 1'b0;
               temp_valid_q <= 1'b0;
               s_ready_q    <= 1'b0;
            end else begin
               m_valid_q    <= m_valid_d;
               temp_valid_q <= temp_valid_d;
               s_ready_q    <= s_ready_d;
            end
         end

         // NOTE: payload registers are reset as well so the outputs read zero
         // (not X) while reset is held; they are flops, not a memory array.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               m_payload_q    <= '0;
               temp_payload_q <= '0;
            end else begin
               if (load_out_from_in) begin
                  m_payload_q <= s_payload_i;
               end else if (load_out_from_temp) begin
                  m_payload_q <= temp_payload_q;
               end
               if (load_temp) begin
                  temp_payload_q <= s_payload_i;
               end
            end
         end

         assign s_ready_o   = s_ready_q;
         assign m_payload_o = m_payload_q;
         assign m_valid_o   = m_valid_q;

      end else if (REG_TYPE == REG_SIMPLE) begin : g_simple
         logic [PAYLOAD_W-1:0] m_payload_q;
         logic                 m_valid_q;

         // Ready stays combinational so a full stage can reload in the same
         // cycle it empties, giving one beat per cycle without a skid slot.
         assign s_ready_o = !m_valid_q || m_ready_i;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               m_payload_q <= '0;
               m_valid_q   <= 1'b0;
            end else if (s_valid_i && s_ready_o) begin
               m_payload_q <= s_payload_i;
               m_valid_q   <= 1'b1;
            end else if (m_ready_i) begin
               m_valid_q <= 1'b0;
            end
         end

         assign m_payload_o = m_payload_q;
         assign m_valid_o   = m_valid_q;

      end else begin : g_bypass
         assign s_ready_o   = m_ready_i;
         assign m_payload_o = s_payload_i;
         assign m_valid_o   = s_valid_i;
      end
   endgenerate

endmodule

// File: rtl/axis_pipeline_register.sv
// AXI4-Stream register pipeline: LENGTH cascaded stages of REG_TYPE, or plain
// wires for bypass. Define AXIS_PIPELINE_KEEP_EN to carry tkeep with each beat.
module axis_pipeline_register
   import axis_pipeline_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int REG_TYPE   = REG_SKID,
   parameter int LENGTH     = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
`ifdef AXIS_PIPELINE_KEEP_EN
   input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
`endif
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   input  logic                    s_axis_tlast,
   output logic [DATA_WIDTH-1:0]   m_axis_tdata,
`ifdef AXIS_PIPELINE_KEEP_EN
   output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
`endif
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic                    m_axis_tlast
);

`ifdef AXIS_PIPELINE_KEEP_EN
   localparam int KEEP_W    = keep_width(DATA_WIDTH);
   localparam int PAYLOAD_W = DATA_WIDTH + KEEP_W + 1;
`else
   localparam int PAYLOAD_W = DATA_WIDTH + 1;
`endif

   logic [PAYLOAD_W-1:0] s_payload;
   logic [PAYLOAD_W-1:0] m_payload;

`ifdef AXIS_PIPELINE_KEEP_EN
   assign s_payload = {s_axis_tkeep, s_axis_tlast, s_axis_tdata};
   assign {m_axis_tkeep, m_axis_tlast, m_axis_tdata} = m_payload;
`else
   assign s_payload = {s_axis_tlast, s_axis_tdata};
   assign {m_axis_tlast, m_axis_tdata} = m_payload;
`endif

   generate
      if (LENGTH == 0 || REG_TYPE == REG_BYPASS) begin : g_bypass
         assign m_payload     = s_payload;
         assign m_axis_tvalid = s_axis_tvalid;
         assign s_axis_tready = m_axis_tready;
      end else begin : g_chain
         // Element k is the slave side of stage k; element LENGTH is the output.
         logic [PAYLOAD_W-1:0] payload [LENGTH+1];
         logic                 valid   [LENGTH+1];
         logic                 ready   [LENGTH+1];

         assign payload[0]     = s_payload;
         assign valid[0]       = s_axis_tvalid;
         assign s_axis_tready  = ready[0];
         assign m_payload      = payload[LENGTH];
         assign m_axis_tvalid  = valid[LENGTH];
         assign ready[LENGTH]  = m_axis_tready;

         for (genvar k = 0; k < LENGTH; k++) begin : g_stage
            axis_register_stage #(
               .PAYLOAD_W (PAYLOAD_W),
               .REG_TYPE  (REG_TYPE)
            ) u_stage (
               .clk         (clk),
               .rst         (rst),
               .s_payload_i (payload[k]),
               .s_valid_i   (valid[k]),
               .s_ready_o   (ready[k]),
               .m_payload_o (payload[k+1]),
               .m_valid_o   (valid[k+1]),
               .m_ready_i   (ready[k+1])
            );
         end
      end
   endgenerate

endmodule

// File: tb/tb_axis_pipeline_register.sv
// Directed bench: skid (type 2, LENGTH 2), simple (type 1, LENGTH 3) and
// bypass instances exercised for reset, streaming, backpressure and bypass.
module tb_axis_pipeline_register;

   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // skid instance
   logic [DW-1:0] sk_s_tdata, sk_m_tdata;
   logic          sk_s_tvalid, sk_s_tready, sk_s_tlast;
   logic          sk_m_tvalid, sk_m_tready, sk_m_tlast;
   // simple instance
   logic [DW-1:0] sp_s_tdata, sp_m_tdata;
   logic          sp_s_tvalid, sp_s_tready, sp_s_tlast;
   logic          sp_m_tvalid, sp_m_tready, sp_m_tlast;
   // bypass instance
   logic [DW-1:0] bp_s_tdata, bp_m_tdata;
   logic          bp_s_tvalid, bp_s_tready, bp_s_tlast;
   logic          bp_m_tvalid, bp_m_tready, bp_m_tlast;

`ifdef AXIS_PIPELINE_KEEP_EN
   logic [DW/8-1:0] s_keep = '1;
   logic [DW/8-1:0] sk_m_tkeep, sp_m_tkeep, bp_m_tkeep;
`endif

   axis_pipeline_register #(.DATA_WIDTH(DW), .REG_TYPE(axis_pipeline_pkg::REG_SKID), .LENGTH(2)) u_skid (
      .clk (clk), .rst (rst),
      .s_axis_tdata (sk_s_tdata),
`ifdef AXIS_PIPELINE_KEEP_EN
      .s_axis_tkeep (s_keep), .m_axis_tkeep (sk_m_tkeep),
`endif
      .s_axis_tvalid (sk_s_tvalid), .s_axis_tready (sk_s_tready), .s_axis_tlast (sk_s_tlast),
      .m_axis_tdata (sk_m_tdata), .m_axis_tvalid (sk_m_tvalid), .m_axis_tready (sk_m_tready),
      .m_axis_tlast (sk_m_tlast)
   );

   axis_pipeline_register #(.DATA_WIDTH(DW), .REG_TYPE(axis_pipeline_pkg::REG_SIMPLE), .LENGTH(3)) u_simple (
      .clk (clk), .rst (rst),
      .s_axis_tdata (sp_s_tdata),
`ifdef AXIS_PIPELINE_KEEP_EN
      .s_axis_tkeep (s_keep), .m_axis_tkeep (sp_m_tkeep),
`endif
      .s_axis_tvalid (sp_s_tvalid), .s_axis_tready (sp_s_tready), .s_axis_tlast (sp_s_tlast),
      .m_axis_tdata (sp_m_tdata), .m_axis_tvalid (sp_m_tvalid), .m_axis_tready (sp_m_tready),
      .m_axis_tlast (sp_m_tlast)
   );

   axis_pipeline_register #(.DATA_WIDTH(DW), .REG_TYPE(axis_pipeline_pkg::REG_BYPASS), .LENGTH(0)) u_bypass (
      .clk (clk), .rst (rst),
      .s_axis_tdata (bp_s_tdata),
`ifdef AXIS_PIPELINE_KEEP_EN
      .s_axis_tkeep (s_keep), .m_axis_tkeep (bp_m_tkeep),
`endif
      .s_axis_tvalid (bp_s_tvalid), .s_axis_tready (bp_s_tready), .s_axis_tlast (bp_s_tlast),
      .m_axis_tdata (bp_m_tdata), .m_axis_tvalid (bp_m_tvalid), .m_axis_tready (bp_m_tready),
      .m_axis_tlast (bp_m_tlast)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Inputs are driven at posedge+1 and outputs/handshakes sampled at posedge+2.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [DW-1:0] data;
      logic          valid, last, m_ready;
      logic [DW-1:0] exp_data;
      logic          exp_valid, exp_last, exp_s_ready;
   } byp_vec_t;

   byp_vec_t byp_tab[6];

   logic [DW-1:0] q32[$];
   logic [DW:0]   q33[$];
   logic [DW:0]   exp33;
   logic [DW-1:0] cur_data;
   logic          cur_last;
   int w, nin, nout, occ, max_occ, first_acc, first_out, last_out;
   int first_low, last_low, full_rate, stall_cnt, vcount;
   localparam int W0 = 10;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      byp_tab[0] = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0};
      byp_tab[1] = '{32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1};
      byp_tab[2] = '{32'h1234_5678, 1'b1, 1'b1, 1'b0, 32'h1234_5678, 1'b1, 1'b1, 1'b0};
      byp_tab[3] = '{32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1};
      byp_tab[4] = '{32'hA5A5_A5A5, 1'b1, 1'b1, 1'b1, 32'hA5A5_A5A5, 1'b1, 1'b1, 1'b1};
      byp_tab[5] = '{32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 1'b0};

      // ---------------- reset with random inputs ----------------
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         sk_s_tdata = $urandom; sk_s_tvalid = 1'($urandom_range(0, 1));
         sk_s_tlast = 1'($urandom_range(0, 1)); sk_m_tready = 1'($urandom_range(0, 1));
         sp_s_tdata = $urandom; sp_s_tvalid = 1'($urandom_range(0, 1));
         sp_s_tlast = 1'($urandom_range(0, 1)); sp_m_tready = 1'($urandom_range(0, 1));
         bp_s_tdata = $urandom; bp_s_tvalid = 1'($urandom_range(0, 1));
         bp_s_tlast = 1'($urandom_range(0, 1)); bp_m_tready = 1'($urandom_range(0, 1));
         #1;
         check("rst skid m_tvalid", sk_m_tvalid, 0);
         check("rst skid m_tdata", sk_m_tdata, 0);
         check("rst skid m_tlast", sk_m_tlast, 0);
         check("rst skid s_tready", sk_s_tready, 0);
         check("rst simple m_tvalid", sp_m_tvalid, 0);
         check("rst simple m_tdata", sp_m_tdata, 0);
         check("rst simple s_tready", sp_s_tready, 1);
         check("rst bypass tdata", bp_m_tdata, bp_s_tdata);
         step();
      end
      sk_s_tvalid = 1'b0; sp_s_tvalid = 1'b0; bp_s_tvalid = 1'b0;
      sk_m_tready = 1'b1; sp_m_tready = 1'b1;
      rst = 1'b0;
      #1;
      check("skid s_tready before first edge", sk_s_tready, 0);
      step();
      check("skid s_tready after first edge", sk_s_tready, 1);

      // ---------------- bypass table ----------------
      foreach (byp_tab[i]) begin
         bp_s_tdata  = byp_tab[i].data;
         bp_s_tvalid = byp_tab[i].valid;
         bp_s_tlast  = byp_tab[i].last;
         bp_m_tready = byp_tab[i].m_ready;
         #1;
         check("byp tab tdata", bp_m_tdata, byp_tab[i].exp_data);
         check("byp tab tvalid", bp_m_tvalid, byp_tab[i].exp_valid);
         check("byp tab tlast", bp_m_tlast, byp_tab[i].exp_last);
         check("byp tab s_tready", bp_s_tready, byp_tab[i].exp_s_ready);
      end
      for (int i = 0; i < 20; i++) begin
         bp_s_tdata = $urandom; bp_s_tvalid = 1'($urandom_range(0, 1));
         bp_s_tlast = 1'($urandom_range(0, 1)); bp_m_tready = 1'($urandom_range(0, 1));
         #1;
         check("byp rnd tdata", bp_m_tdata, bp_s_tdata);
         check("byp rnd tvalid", bp_m_tvalid, bp_s_tvalid);
         check("byp rnd tlast", bp_m_tlast, bp_s_tlast);
         check("byp rnd s_tready", bp_s_tready, bp_m_tready);
      end
      bp_s_tvalid = 1'b0;
      step();

      // ---------------- skid streaming: 100 beats ----------------
      nin = 0; nout = 0; w = 0; first_acc = -1; first_out = -1; last_out = -1;
      sk_m_tready = 1'b1;
      while (nout < 100 && w < 400) begin
         sk_s_tvalid = (nin < 100);
         sk_s_tdata  = DW'(nin);
         sk_s_tlast  = (nin == 99);
         #1;
         if (sk_s_tvalid && sk_s_tready) begin
            if (first_acc < 0) first_acc = w;
            nin++;
         end
         if (sk_m_tvalid && sk_m_tready) begin
            if (first_out < 0) first_out = w;
            last_out = w;
            check("stream tdata", sk_m_tdata, nout);
            check("stream tlast", sk_m_tlast, (nout == 99));
            nout++;
         end
         step();
         w++;
      end
      check("stream beat count", nout, 100);
      check("stream latency", first_out - first_acc, 2);
      check("stream consecutive", last_out - first_out, 99);

      // ---------------- skid backpressure ----------------
      q32.delete();
      nin = 0; nout = 0; occ = 0; max_occ = 0; first_low = -1; last_low = -1; full_rate = 0;
      for (int win = 0; win < 60; win++) begin
         logic in_hs, out_hs;
         sk_s_tvalid = (win < 30);
         sk_s_tdata  = 32'h1000 + DW'(nin);
         sk_s_tlast  = 1'b0;
         sk_m_tready = !(win >= W0 && win < W0 + 5);
         #1;
         in_hs  = sk_s_tvalid && sk_s_tready;
         out_hs = sk_m_tvalid && sk_m_tready;
         if (win < 30 && !sk_s_tready) begin
            if (first_low < 0) first_low = win;
            last_low = win;
         end
         if (in_hs) begin
            q32.push_back(sk_s_tdata);
            nin++;
         end
         if (out_hs) begin
            check("bp beat expected", (q32.size() != 0), 1);
            if (q32.size() != 0) check("bp tdata", sk_m_tdata, q32.pop_front());
            nout++;
         end
         if (win >= W0 + 8 && win < W0 + 20 && in_hs && out_hs) full_rate++;
         occ = occ + int'(in_hs) - int'(out_hs);
         if (occ > max_occ) max_occ = occ;
         step();
      end
      check("bp max buffered", max_occ, 4);
      check("bp first ready low", first_low, W0 + 2);
      check("bp last ready low", last_low, W0 + 6);
      check("bp full rate after release", full_rate, 12);
      check("bp drained", q32.size(), 0);
      check("bp in/out count", nout, nin);

      // ---------------- simple type, random backpressure ----------------
      q33.delete();
      nin = 0; nout = 0; occ = 0; max_occ = 0; stall_cnt = 0; w = 0;
      first_acc = -1; first_out = -1;
      cur_data = $urandom; cur_last = 1'b0;
      while (nout < 1000 && w < 6000) begin
         logic in_hs, out_hs;
         sp_s_tvalid = (nin < 1000);
         sp_s_tdata  = cur_data;
         sp_s_tlast  = cur_last;
         sp_m_tready = (w < 20) ? 1'b1 : 1'($urandom_range(0, 1));
         #1;
         in_hs  = sp_s_tvalid && sp_s_tready;
         out_hs = sp_m_tvalid && sp_m_tready;
         if (sp_s_tvalid && sp_m_tready && !sp_s_tready) stall_cnt++;
         if (in_hs) begin
            if (first_acc < 0) first_acc = w;
            q33.push_back({sp_s_tlast, sp_s_tdata});
            nin++;
            cur_data = $urandom;
            cur_last = ((nin % 7) == 6);
         end
         if (out_hs) begin
            if (first_out < 0) first_out = w;
            check("t1 beat expected", (q33.size() != 0), 1);
            if (q33.size() != 0) begin
               exp33 = q33.pop_front();
               check("t1 payload", {sp_m_tlast, sp_m_tdata}, exp33);
            end
            nout++;
         end
         occ = occ + int'(in_hs) - int'(out_hs);
         if (occ > max_occ) max_occ = occ;
         step();
         w++;
      end
      sp_s_tvalid = 1'b0;
      check("t1 beat count", nout, 1000);
      check("t1 latency", first_out - first_acc, 3);
      check("t1 stalls with ready high", stall_cnt, 0);
      check("t1 capacity", max_occ, 3);
      check("t1 drained", q33.size(), 0);

      // ---------------- reset mid-packet (skid) ----------------
      sk_m_tready = 1'b0;
      nin = 0; w = 0;
      while (nin < 3 && w < 20) begin
         sk_s_tvalid = 1'b1;
         sk_s_tdata  = 32'hA0 + DW'(nin);
         sk_s_tlast  = (nin == 7);
         #1;
         if (sk_s_tvalid && sk_s_tready) nin++;
         if (nin < 3) step();
         w++;
      end
      check("mid-pkt beats accepted", nin, 3);
      step();
      sk_s_tvalid = 1'b0;
      #1;
      check("mid-pkt valid before reset", sk_m_tvalid, 1);
      rst = 1'b1;
      #1;
      check("mid-pkt async valid drop", sk_m_tvalid, 0);
      check("mid-pkt async tdata clear", sk_m_tdata, 0);
      check("mid-pkt s_tready in reset", sk_s_tready, 0);
      step();
      step();
      rst = 1'b0;
      sk_m_tready = 1'b1;
      vcount = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (sk_m_tvalid) vcount++;
         step();
      end
      check("mid-pkt no stale beats", vcount, 0);
      nin = 0; nout = 0;
      for (int i = 0; i < 30 && nout < 4; i++) begin
         sk_s_tvalid = (nin < 4);
         sk_s_tdata  = 32'hB0 + DW'(nin);
         sk_s_tlast  = (nin == 3);
         #1;
         if (sk_s_tvalid && sk_s_tready) nin++;
         if (sk_m_tvalid && sk_m_tready) begin
            check("post-rst tdata", sk_m_tdata, 32'hB0 + nout);
            check("post-rst tlast", sk_m_tlast, (nout == 3));
            nout++;
         end
         step();
      end
      sk_s_tvalid = 1'b0;
      check("post-rst beat count", nout, 4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/axis_pipeline_register.md
# axis_pipeline_register

Parametrised AXI4-Stream register pipeline: a chain of `LENGTH` identical register stages between a slave and a master AXI4-Stream port. It breaks combinational paths on data, valid and (in skid mode) ready. Full throughput is sustained under arbitrary backpressure with no beat loss or duplication. It replaces plain pass-through stream connections wherever timing closure needs registered boundaries.

## Interface
- `DATA_WIDTH`, 32: tdata width in bits; must be a multiple of 8 when `AXIS_PIPELINE_KEEP_EN` is defined.
- `REG_TYPE`, 2: 0 = bypass (wires), 1 = pipeline register (forward-registered, ready combinational), 2 = skid buffer (all outputs registered).
- `LENGTH`, 2: number of cascaded stages; 0 behaves as bypass regardless of `REG_TYPE`.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `s_axis_tdata` in DATA_WIDTH: input data.
- `s_axis_tvalid` in 1: input valid.
- `s_axis_tready` out 1: input ready.
- `s_axis_tlast` in 1: input end-of-packet.
- `m_axis_tdata` out DATA_WIDTH: output data.
- `m_axis_tvalid` out 1: output valid.
- `m_axis_tready` in 1: output ready.
- `m_axis_tlast` out 1: output end-of-packet.

## Operation
- A beat transfers on a port when valid and ready are both high at a rising edge. tdata and tlast travel together as one payload.
- Ordering is strict FIFO. Each accepted beat appears exactly once at the output.
- REG_TYPE 0 / LENGTH 0: all signals pass straight through. There is no state and no reset effect.
- REG_TYPE 1 stage: one output register.
  - `s_tready = !m_valid_reg || m_tready`.
  - On a transfer in, the register loads and valid is set.
  - On a transfer out with no transfer in, valid is cleared.
- REG_TYPE 2 stage: output register plus one skid (temp) register.
  - `s_tready_reg` next is `m_tready || (!temp_valid && (!m_valid || !s_valid))`.
  - A beat accepted while the output is held goes to temp.
  - When the output drains, temp moves to output before any new input.
  - A beat is never accepted while temp is full.
- Stage k's master side drives stage k+1's slave side. Ready propagates stage by stage.
- Reset (asserted): all valid flags and temp flags are cleared, `s_axis_tready` = 0, and data/last registers = 0. Outputs at reset for REG_TYPE 1/2: `m_axis_tvalid` 0, `m_axis_tdata` 0, `m_axis_tlast` 0. `s_axis_tready` is 0 during reset for type 2 and evaluates to 1 for type 1.
- Reset mid-packet: all in-flight beats are discarded. No partial packet is completed. The upstream side is responsible for restarting.
- The block does not check packet framing. tlast is carried unchanged.

## Timing
- Latency for REG_TYPE 1/2 is `LENGTH` cycles from input transfer to `m_axis_tvalid` for an empty pipeline with `m_axis_tready` held high.
- Throughput is one beat per cycle in steady state for both types. Type 1 sustains it through its combinational ready path.
- Type 2: `s_axis_tready` is a register output. It deasserts the cycle after backpressure reaches the first stage, and reasserts one cycle after downstream ready returns.
- Pipeline capacity is `LENGTH` beats for type 1 and `2*LENGTH` beats for type 2.
- Type 2: `s_axis_tready` rises on the first clock edge after `rst` deasserts.
- Simultaneous input and output transfer on a full type-1 stage: the register reloads and valid stays 1, with no bubble.
- A changing `s_axis_tvalid`/data without a handshake is not captured. Upstream AXI rules are assumed and are not checked.

## Configuration
- `AXIS_PIPELINE_KEEP_EN` defined: adds ports `s_axis_tkeep` in DATA_WIDTH/8 and `m_axis_tkeep` out DATA_WIDTH/8. tkeep is carried with each beat like tlast, and its reset value is all-zero.
- Not defined: there are no tkeep ports. Payload is tdata and tlast only.

## Structure
- Package `axis_pipeline_pkg` holds the REG_TYPE constants (`REG_BYPASS`=0, `REG_SIMPLE`=1, `REG_SKID`=2) and the keep-width function `keep_width(DATA_WIDTH)`.
- Sub-module `axis_register_stage` implements one stage of either type. The top level is a generate loop of `LENGTH` instances plus bypass wiring.

## Test plan
- Reset: hold `rst`=1 with random inputs. Required: `m_axis_tvalid`=0 and `m_axis_tdata`=0; type 2 also `s_axis_tready`=0. After release, type 2 `s_axis_tready`=1 one edge later.
- Streaming: LENGTH=2, type 2, send 100 beats `tdata`=0..99 with tlast on beat 99 and `m_axis_tready`=1. Required: output first valid 2 cycles after first accept, 100 consecutive cycles, identical data, tlast only on 99.
- Backpressure: type 2, continuous input, drop `m_axis_tready` for 5 cycles. Required: exactly 4 beats buffered, `s_axis_tready` low from the cycle after the stall reaches stage 0, no loss or duplicate, full rate on release.
- Type 1 throughput: type 1, LENGTH=3, random `m_axis_tready` at 50%, 1000 beats. Required: output sequence equals input, and the input is never stalled while `m_axis_tready`=1 continuously.
- Reset mid-packet: assert `rst` after 3 of 8 beats are in flight. Required: `m_axis_tvalid` drops to 0 asynchronously, and no pre-reset beat appears after release.
- Bypass: LENGTH=0 and REG_TYPE 0, random traffic. Required: outputs equal inputs in the same cycle, and `s_axis_tready`==`m_axis_tready`.
